mc_main_control: RTL
====================

// Module: mc_main_control
// PURPOSE
//  Main control FSM of the multi-cycle MIPS datapath; drives every datapath enable/mux select and the 2-bit ALUop consumed by ALU_CU.
//  Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK per instruction from the IR opcode field.
//  Supports R-type (add/sub/addu/and/or/nor via funct), lw, sw, beq, j.
//  Memory states stretch to MEM_LAT cycles so slower memories plug in without datapath changes.
// PARAMETERS
//  MEM_LAT  1  cycles each memory state (FETCH, MEMRD, MEMWR) is held; legal 1..15
// PORTS
//  clk          in   1  rising-edge clock, single domain
//  rst          in   1  synchronous, active-high reset
//  Op           in   6  IR[31:26]; sampled in DECODE only
//  PCWrite      out  1  unconditional PC load
//  PCWriteCond  out  1  PC load if ALU Zero (beq)
//  IorD         out  1  0=PC, 1=ALUOut as memory address
//  MemRead      out  1  memory read strobe
//  MemWrite     out  1  memory write strobe
//  MemtoReg     out  1  0=ALUOut, 1=MDR to register write data
//  IRWrite      out  1  IR load
//  PCSource     out  2  00=ALU result, 01=ALUOut, 10=jump target
//  ALUop        out  2  00=addu, 01=sub, 10=decode funct (to ALU_CU)
//  ALUSrcA      out  1  0=PC, 1=A
//  ALUSrcB      out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
//  RegWrite     out  1  register file write enable
//  RegDst       out  1  0=rt, 1=rd
//  IllegalOp    out  1  one-cycle pulse: unsupported opcode seen in DECODE
//  State        out  4  current state, debug
// BEHAVIOUR
//  States (4-bit): FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXEC=6 ALUWB=7 BRANCH=8 JUMP=9; 10..15 illegal -> FETCH next cycle.
//  Outputs Moore-decoded from registered State (+wait counter); signals not listed for a state are 0.
//  FETCH : MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00; IRWrite=PCWrite=1 only on final wait cycle.
//  DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=00.
//  MEMADR: ALUSrcA=1, ALUSrcB=10, ALUop=00.
//  MEMRD : MemRead=1, IorD=1 (all MEM_LAT cycles).   MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
//  MEMWR : MemWrite=1, IorD=1 (all MEM_LAT cycles).
//  EXEC  : ALUSrcA=1, ALUSrcB=00, ALUop=10.          ALUWB: RegWrite=1, RegDst=1, MemtoReg=0.
//  BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01.
//  JUMP  : PCWrite=1, PCSource=10.
//  Transitions: FETCH->DECODE after MEM_LAT cycles; DECODE by Op: 000000->EXEC, 100011/101011->MEMADR, 000100->BRANCH, 000010->JUMP, other->FETCH with IllegalOp=1 that cycle.
//  MEMADR->MEMRD (lw) / MEMWR (sw), Op still from IR; MEMRD->MEMWB after MEM_LAT; MEMWR->FETCH after MEM_LAT.
//  MEMWB, ALUWB, BRANCH, JUMP -> FETCH. EXEC->ALUWB.
//  Wait counter: 4-bit, cleared on entry to each memory state, increments each cycle there; last cycle when count==MEM_LAT-1. MEM_LAT=1: single cycle, no stall.
//  Cycle counts (MEM_LAT=1): lw 5, sw 4, R-type 4, beq 3, j 3, illegal 2.
//  Reset: rst sampled high -> State=FETCH, counter=0 next edge. While rst high, all write/strobe outputs (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite) and IllegalOp forced 0. Other outputs take FETCH values once State=FETCH.
//  Reset mid-instruction aborts it; no partial write occurs after the reset edge.
//  Op is don't-care outside DECODE/MEMADR; X on Op elsewhere must not propagate to outputs.
// STRUCTURE
//  Shared package/include (mc_defs.vh): state encodings, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J), ALUop codes (ALUOP_ADDU=00, ALUOP_SUB=01, ALUOP_FUNCT=10), ALUSrcB/PCSource select codes.
//  One sub-module: mc_mem_wait_cnt (clear, enable, MEM_LAT param, last-cycle flag).
//  Next-state logic and output decode stay in this module as two case blocks.
// TESTING
//  1 reset, Op=100011, MEM_LAT=1 -> states 0,1,2,3,4,0; MEMRD IorD=1 MemRead=1; MEMWB RegWrite=1 MemtoReg=1 RegDst=0.
//  2 Op=000000 -> 0,1,6,7,0; EXEC ALUop=10 ALUSrcA=1 ALUSrcB=00; ALUWB RegWrite=1 RegDst=1. Check against ALU_CU: funct 100010 -> Out=001.
//  3 Op=000100 -> 0,1,8,0; BRANCH ALUop=01 PCWriteCond=1 PCSource=01.
//  4 Op=000010 -> 0,1,9,0 with PCWrite=1 PCSource=10; Op=111111 -> 0,1,0 with IllegalOp pulse of exactly 1 cycle.
//  5 MEM_LAT=3, Op=101011 -> FETCH 3 cycles (IRWrite/PCWrite only on 3rd), MEMWR 3 cycles with MemWrite=1; total 8 cycles.
//  6 rst asserted during MEMWR cycle 2 -> MemWrite=0 that cycle; State=FETCH, counter=0 after the edge; the next instruction runs normally.

Source files
------------

// File: rtl/mc_main_control_pkg.sv
// Shared encodings for the multi-cycle MIPS main control: FSM states, opcodes,
// ALUop codes and datapath mux select codes.
package mc_main_control_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_ALUWB  = 4'd7,
        ST_BRANCH = 4'd8,
        ST_JUMP   = 4'd9
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADDU  = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH  = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that touch memory and are therefore stretched to MEM_LAT cycles.
    function automatic logic is_mem_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
    endfunction

endpackage

// File: rtl/mc_mem_wait_cnt.sv
// Memory-state wait counter: counts cycles spent in a memory state and flags
// the final one (count == MEM_LAT-1); clear has priority over enable.
module mc_mem_wait_cnt #(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 4'd0;
        end else if (en) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == LAST_CNT);

endmodule

// File: rtl/mc_main_control.sv
// Main control FSM of the multi-cycle MIPS datapath: Moore-decoded enables and
// mux selects per state; memory states are held MEM_LAT cycles.
module mc_main_control
    import mc_main_control_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic [1:0] PCSource,
    output logic [1:0] ALUop,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       IllegalOp,
    output logic [3:0] State
);

    state_e state_q;
    state_e state_d;
    logic   in_mem;
    logic   wait_last;
    logic   illegal_d;

    assign in_mem = is_mem_state(state_q);

    // Clearing on the last cycle (or outside memory states) guarantees every
    // memory state is entered with a zero count.
    mc_mem_wait_cnt #(
        .MEM_LAT(MEM_LAT)
    ) u_wait_cnt (
        .clk (clk),
        .rst (rst),
        .clr (!in_mem || wait_last),
        .en  (in_mem),
        .last(wait_last)
    );

    always_comb begin
        state_d   = ST_FETCH;
        illegal_d = 1'b0;
        case (state_q)
            ST_FETCH:  state_d = wait_last ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (Op)
                    OP_RTYPE:     state_d = ST_EXEC;
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    default: begin
                        state_d   = ST_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_MEMADR: state_d = (Op == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:  state_d = wait_last ? ST_MEMWB : ST_MEMRD;
            ST_MEMWR:  state_d = wait_last ? ST_FETCH : ST_MEMWR;
            ST_EXEC:   state_d = ST_ALUWB;
            default:   state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        PCSource    = PCSRC_ALU;
        ALUop       = ALUOP_ADDU;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        IllegalOp   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = wait_last;
                PCWrite = wait_last;
            end
            ST_DECODE: begin
                ALUSrcB   = SRCB_IMMSH;
                IllegalOp = illegal_d;
            end
            ST_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            ST_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            ST_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            ST_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            ST_EXEC: begin
                ALUSrcA = 1'b1;
                ALUop   = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            ST_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUop       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            default: ;
        endcase
        // Reset must suppress every architectural write in the cycle it is seen.
        if (rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            IllegalOp   = 1'b0;
        end
    end

    assign State = state_q;

endmodule
